// File: rtl/led_pwm_pkg.sv
// Shared definitions for the LED PWM PIO: register map, channel modes and the
// per-channel output function.
package led_pwm_pkg;

   localparam int ADDR_CTRL     = 0;
   localparam int ADDR_PRESCALE = 1;
   localparam int ADDR_BLINK    = 2;
   localparam int ADDR_STATUS   = 3;
   localparam int ADDR_CH_BASE  = 4;

   localparam int MODE_LSB  = 16;
   localparam int MODE_MSB  = 17;
   localparam int PHASE_BIT = 31;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_ON    = 2'd1,
      MODE_PWM   = 2'd2,
      MODE_BLINK = 2'd3
   } mode_t;

   function automatic logic chan_out(input mode_t mode, input logic pwm_on, input logic phase);
      logic lit;
      lit = 1'b0;
      case (mode)
         MODE_OFF:   lit = 1'b0;
         MODE_ON:    lit = 1'b1;
         MODE_PWM:   lit = pwm_on;
         MODE_BLINK: lit = pwm_on & phase;
         default:    lit = 1'b0;
      endcase
      return lit;
   endfunction

endpackage

// File: rtl/led_pwm_pio_if.sv
// Avalon-MM slave bundle between the lightweight HPS bridge and the LED PIO.
interface led_pwm_pio_if #(
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] avs_address;
   logic              avs_write;
   logic [31:0]       avs_writedata;
   logic              avs_read;
   logic [31:0]       avs_readdata;

   modport master (
      output avs_address, avs_write, avs_writedata, avs_read,
      input  avs_readdata
   );

   modport slave (
      input  avs_address, avs_write, avs_writedata, avs_read,
      output avs_readdata
   );
endinterface

// File: rtl/led_pwm_timebase.sv
// Shared timebase: prescaler tick, free-running PWM counter and blink phase.
// All counters sit at zero while disabled so enabling restarts a clean pattern.
module led_pwm_timebase
   import led_pwm_pkg::*;
#(
   parameter int PWM_BITS   = 8,
   parameter int PRESC_BITS = 16,
   parameter int BLINK_BITS = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [PRESC_BITS-1:0] prescale,
   input  logic [BLINK_BITS-1:0] blink,
   output logic [PWM_BITS-1:0]   pwm_cnt,
   output logic                  period_end,
   output logic                  phase
);

   logic [PRESC_BITS-1:0] presc_cnt;
   logic [BLINK_BITS-1:0] blink_cnt;
   logic                  tick;

   // >= rather than == so lowering a limit below the running count wraps at once
   assign tick       = en && (presc_cnt >= prescale);
   assign period_end = tick && (pwm_cnt == '1);

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         presc_cnt <= '0;
         pwm_cnt   <= '0;
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else begin
         presc_cnt <= tick ? '0 : presc_cnt + PRESC_BITS'(1);
         if (tick)
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
         if (period_end) begin
            if (blink_cnt >= blink) begin
               blink_cnt <= '0;
               phase     <= ~phase;
            end else begin
               blink_cnt <= blink_cnt + BLINK_BITS'(1);
            end
         end
      end
   end

endmodule

// File: rtl/led_pwm_pio.sv
// LED PIO with per-channel off/on/PWM/blink-PWM modes behind an Avalon-MM
// register file; read data is registered with a fixed latency of one cycle.
module led_pwm_pio
   import led_pwm_pkg::*;
#(
   parameter int NUM_CH     = 8,
   parameter int PWM_BITS   = 8,
   parameter int PRESC_BITS = 16,
   parameter int BLINK_BITS = 8,
   parameter int ADDR_W     = 5
) (
   input  logic              clk_clk,
   input  logic              reset_reset,
   led_pwm_pio_if.slave      avs,
   output logic [NUM_CH-1:0] leds_export
);

   logic                  ctrl_en;
   logic [PRESC_BITS-1:0] prescale;
   logic [BLINK_BITS-1:0] blink;
   logic [PWM_BITS-1:0]   duty [NUM_CH];
   mode_t                 mode [NUM_CH];

   logic [PWM_BITS-1:0]   pwm_cnt;
   logic                  phase;
   logic                  unused_period_end;
   logic                  unused_wdata;
   logic [31:0]           rdata_next;
   logic [NUM_CH-1:0]     led_next;

   assign unused_wdata = ^avs.avs_writedata;

   led_pwm_timebase #(
      .PWM_BITS   (PWM_BITS),
      .PRESC_BITS (PRESC_BITS),
      .BLINK_BITS (BLINK_BITS)
   ) u_timebase (
      .clk        (clk_clk),
      .rst        (reset_reset),
      .en         (ctrl_en),
      .prescale   (prescale),
      .blink      (blink),
      .pwm_cnt    (pwm_cnt),
      .period_end (unused_period_end),
      .phase      (phase)
   );

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         ctrl_en  <= 1'b0;
         prescale <= '0;
         blink    <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            duty[i] <= '0;
            mode[i] <= MODE_OFF;
         end
      end else if (avs.avs_write) begin
         if (avs.avs_address == ADDR_W'(ADDR_CTRL))
            ctrl_en <= avs.avs_writedata[0];
         if (avs.avs_address == ADDR_W'(ADDR_PRESCALE))
            prescale <= avs.avs_writedata[PRESC_BITS-1:0];
         if (avs.avs_address == ADDR_W'(ADDR_BLINK))
            blink <= avs.avs_writedata[BLINK_BITS-1:0];
         for (int i = 0; i < NUM_CH; i++) begin
            if (avs.avs_address == ADDR_W'(ADDR_CH_BASE + i)) begin
               duty[i] <= avs.avs_writedata[PWM_BITS-1:0];
               mode[i] <= mode_t'(avs.avs_writedata[MODE_MSB:MODE_LSB]);
            end
         end
      end
   end

   always_comb begin
      rdata_next = '0;
      if (avs.avs_address == ADDR_W'(ADDR_CTRL))
         rdata_next[0] = ctrl_en;
      if (avs.avs_address == ADDR_W'(ADDR_PRESCALE))
         rdata_next[PRESC_BITS-1:0] = prescale;
      if (avs.avs_address == ADDR_W'(ADDR_BLINK))
         rdata_next[BLINK_BITS-1:0] = blink;
      if (avs.avs_address == ADDR_W'(ADDR_STATUS)) begin
         rdata_next[NUM_CH-1:0] = leds_export;
         rdata_next[PHASE_BIT]  = phase;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (avs.avs_address == ADDR_W'(ADDR_CH_BASE + i)) begin
            rdata_next[PWM_BITS-1:0]      = duty[i];
            rdata_next[MODE_MSB:MODE_LSB] = mode[i];
         end
      end
   end

   // Registered before the write lands, so a same-cycle read sees the old value
   always_ff @(posedge clk_clk) begin
      if (reset_reset)
         avs.avs_readdata <= '0;
      else if (avs.avs_read)
         avs.avs_readdata <= rdata_next;
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign led_next[g] = ctrl_en & chan_out(mode[g], pwm_cnt < duty[g], phase);
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset)
         leds_export <= '0;
      else
         leds_export <= led_next;
   end

endmodule

// File: tb/tb_led_pwm_pio.sv
// Self-checking bench for led_pwm_pio: register table, read scoreboard, and
// cycle-counted LED pattern checks for PWM, prescale, blink and enable cases.
module tb_led_pwm_pio;

   localparam int NUM_CH = 8;
   localparam logic [4:0] A_CTRL = 5'd0, A_PRESC = 5'd1, A_BLINK = 5'd2, A_STATUS = 5'd3;
   localparam logic [31:0] ALL = 32'hFFFF_FFFF;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NUM_CH-1:0] leds;

   led_pwm_pio_if #(.ADDR_W(5)) bus ();

   led_pwm_pio #(
      .NUM_CH(NUM_CH), .PWM_BITS(8), .PRESC_BITS(16), .BLINK_BITS(8), .ADDR_W(5)
   ) dut (
      .clk_clk     (clk),
      .reset_reset (rst),
      .avs         (bus),
      .leds_export (leds)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t        vecs [13];
   logic [31:0] exp_q [$];
   logic [31:0] mask_q [$];
   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.avs_address   = a;
      bus.avs_writedata = d;
      bus.avs_write     = 1'b1;
      @(negedge clk);
      bus.avs_write     = 1'b0;
   endtask

   task automatic compare_read(input string name);
      logic [31:0] e, m;
      if (exp_q.size() == 0) begin
         check({name, "_no_expectation"}, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         m = mask_q.pop_front();
         check(name, bus.avs_readdata & m, e & m);
      end
   endtask

   task automatic rd(input logic [4:0] a, input logic [31:0] exp, input logic [31:0] mask,
                     input string name);
      @(negedge clk);
      bus.avs_address = a;
      bus.avs_read    = 1'b1;
      exp_q.push_back(exp);
      mask_q.push_back(mask);
      @(posedge clk);
      #1;
      bus.avs_read = 1'b0;
      compare_read(name);
   endtask

   task automatic count_led(input int ch, input int n, output int hi, output int maxrun);
      int run;
      hi = 0; maxrun = 0; run = 0;
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         if (leds[ch]) begin
            hi++;
            run++;
            if (run > maxrun) maxrun = run;
         end else begin
            run = 0;
         end
      end
   endtask

   initial begin
      int hi, maxrun, bad;
      logic [31:0] held;

      vecs[0]  = '{1'b1, A_CTRL,   32'hFFFF_FFFF, 32'h0000_0001};
      vecs[1]  = '{1'b1, A_CTRL,   32'h0000_0000, 32'h0000_0000};
      vecs[2]  = '{1'b1, A_PRESC,  32'hFFFF_FFFF, 32'h0000_FFFF};
      vecs[3]  = '{1'b1, A_PRESC,  32'h0000_1234, 32'h0000_1234};
      vecs[4]  = '{1'b1, A_BLINK,  32'hFFFF_FFFF, 32'h0000_00FF};
      vecs[5]  = '{1'b1, A_STATUS, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[6]  = '{1'b1, 5'd4,     32'hFFFF_FFFF, 32'h0003_00FF};
      vecs[7]  = '{1'b1, 5'd11,    32'h0001_2345, 32'h0001_0045};
      vecs[8]  = '{1'b1, 5'd31,    32'hFFFF_FFFF, 32'h0000_0000};
      vecs[9]  = '{1'b0, A_PRESC,  32'h0000_0000, 32'h0000_1234};
      vecs[10] = '{1'b0, A_BLINK,  32'h0000_0000, 32'h0000_00FF};
      vecs[11] = '{1'b1, 5'd12,    32'hFFFF_FFFF, 32'h0000_0000};
      vecs[12] = '{1'b0, 5'd4,     32'h0000_0000, 32'h0003_00FF};

      bus.avs_address = '0; bus.avs_write = 1'b0; bus.avs_writedata = '0; bus.avs_read = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      check("reset_leds", 32'(leds), 32'd0);
      check("reset_readdata", bus.avs_readdata, 32'd0);
      rd(A_CTRL, 32'd0, ALL, "reset_ctrl");
      rd(A_STATUS, 32'd0, ALL, "reset_status");

      for (int i = 0; i < 13; i++) begin
         if (vecs[i].wr) wr(vecs[i].addr, vecs[i].wdata);
         rd(vecs[i].addr, vecs[i].exp, ALL, $sformatf("regvec%0d_addr%0d", i, vecs[i].addr));
      end

      held = bus.avs_readdata;
      repeat (4) @(posedge clk);
      #1 check("readdata_hold", bus.avs_readdata, 32'h0003_00FF);

      // same-cycle read and write returns the old value
      wr(5'd5, 32'h0001_0011);
      @(negedge clk);
      bus.avs_address = 5'd5; bus.avs_writedata = 32'h0002_0022;
      bus.avs_write = 1'b1; bus.avs_read = 1'b1;
      exp_q.push_back(32'h0001_0011); mask_q.push_back(ALL);
      @(posedge clk);
      #1;
      bus.avs_write = 1'b0; bus.avs_read = 1'b0;
      compare_read("rw_same_addr_old");
      rd(5'd5, 32'h0002_0022, ALL, "rw_same_addr_new");

      // reset mid-operation
      wr(A_CTRL, 32'd1);
      repeat (5) @(posedge clk);
      #1 check("running_ch7_on", 32'(leds[7]), 32'd1);
      @(negedge clk) rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      check("midreset_leds", 32'(leds), 32'd0);
      check("midreset_readdata", bus.avs_readdata, 32'd0);
      for (int a = 0; a < 13; a++)
         rd(5'(a), 32'd0, ALL, $sformatf("midreset_reg%0d", a));

      // static modes
      wr(5'd4, 32'h0001_0000);
      wr(5'd5, 32'h0000_0000);
      wr(5'd6, 32'h0002_0000);
      wr(A_CTRL, 32'd1);
      repeat (3) @(posedge clk);
      bad = 0;
      for (int k = 0; k < 1000; k++) begin
         @(posedge clk);
         #1 if (leds !== 8'b0000_0001) bad++;
      end
      check("static_modes_bad_cycles", 32'(bad), 32'd0);
      rd(5'd4, 32'h0001_0000, ALL, "ch0_readback");

      // PWM duty at PRESCALE=0
      wr(5'd4, 32'd0);
      wr(5'd6, 32'd0);
      wr(A_CTRL, 32'd0);
      wr(A_PRESC, 32'd0);
      wr(5'd7, 32'h0002_0040);
      wr(A_CTRL, 32'd1);
      count_led(3, 256, hi, maxrun);
      check("pwm_duty64_high", 32'(hi), 32'd64);
      wr(5'd7, 32'h0002_00FF);
      repeat (2) @(posedge clk);
      count_led(3, 256, hi, maxrun);
      check("pwm_duty255_high", 32'(hi), 32'd255);

      // prescale 3, duty 128: 1024-cycle period, 512-cycle high run
      wr(A_CTRL, 32'd0);
      wr(5'd7, 32'h0002_0080);
      wr(A_PRESC, 32'd3);
      wr(A_CTRL, 32'd1);
      count_led(3, 2048, hi, maxrun);
      check("presc3_high", 32'(hi), 32'd1024);
      check("presc3_maxrun", 32'(maxrun), 32'd512);

      // blink: phase toggles every 512 cycles
      wr(A_CTRL, 32'd0);
      wr(A_PRESC, 32'd0);
      wr(A_BLINK, 32'd1);
      wr(5'd7, 32'd0);
      wr(5'd8, 32'h0003_0080);
      wr(A_CTRL, 32'd1);
      count_led(4, 2048, hi, maxrun);
      check("blink_high", 32'(hi), 32'd512);
      check("blink_maxrun", 32'(maxrun), 32'd128);
      wr(A_CTRL, 32'd0);
      wr(A_CTRL, 32'd1);
      repeat (300) @(posedge clk);
      rd(A_STATUS, 32'h0000_0000, 32'h8000_0000, "phase_at_300");
      repeat (400) @(posedge clk);
      rd(A_STATUS, 32'h8000_0000, 32'h8000_0000, "phase_at_700");
      repeat (400) @(posedge clk);
      rd(A_STATUS, 32'h0000_0000, 32'h8000_0000, "phase_at_1100");
      repeat (500) @(posedge clk);
      rd(A_STATUS, 32'h8000_0000, 32'h8000_0000, "phase_at_1600");

      // EN=0 mid-pattern
      wr(5'd4, 32'h0001_0000);
      repeat (3) @(posedge clk);
      #1 check("en1_ch0_lit", 32'(leds[0]), 32'd1);
      wr(A_CTRL, 32'd0);
      @(posedge clk);
      #1 check("en0_leds_off", 32'(leds), 32'd0);
      rd(A_STATUS, 32'd0, ALL, "en0_status");

      // re-enable: counters restart from 0, first tick PRESCALE+1 cycles later
      wr(5'd8, 32'd0);
      wr(5'd4, 32'h0002_0001);
      wr(A_PRESC, 32'd3);
      wr(A_CTRL, 32'd1);
      count_led(0, 20, hi, maxrun);
      check("restart_first_tick", 32'(hi), 32'd4);

      // lowering PRESCALE below the running count wraps immediately
      wr(A_CTRL, 32'd0);
      wr(A_PRESC, 32'd1000);
      wr(A_CTRL, 32'd1);
      repeat (10) @(posedge clk);
      #1 check("presc_large_led", 32'(leds[0]), 32'd1);
      wr(A_PRESC, 32'd0);
      @(posedge clk);
      #1 check("presc_drop_pre", 32'(leds[0]), 32'd1);
      @(posedge clk);
      #1 check("presc_drop_tick", 32'(leds[0]), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
